lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 32-bit address.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned or illegal-size request, valid with rsp_valid.
REQ-014 mem_we  out  1  word-RAM write enable; the RAM writes on the posedge where it is high.
REQ-015 mem_addr  out  32  word address = {2'b00, addr[31:2]}.
REQ-016 mem_wdata  out  32  word written when mem_we = 1.
REQ-017 mem_rdata  in  32  combinational word-RAM read data for the current mem_addr, same cycle.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RMW_RD, STORE and RESP, encoded in one state register.
REQ-019 IDLE: req_ready = 1 (only in IDLE); req_valid = 1 at posedge latches we/size/signed/addr/wdata and leaves IDLE.
REQ-020 Acceptance SHALL route as follows:
- misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size = 11 -> RESP, rsp_err = 1, no memory access;
- load -> LOAD;
- word store -> STORE;
- byte or half store -> RMW_RD.
REQ-021 LOAD SHALL do all of the following:
- drive mem_addr from the latched address;
- capture mem_rdata at the posedge;
- extract the lane (byte lane addr[1:0], half lane addr[1], little-endian);
- extend per req_signed into rsp_rdata;
- go to RESP.
REQ-022 RMW_RD SHALL drive mem_addr, capture mem_rdata into a merge register and go to STORE.
REQ-023 In STORE, mem_we SHALL be 1 for exactly one cycle.
- mem_wdata: req_wdata for word stores; the merged word for sub-word stores, replacing only the addressed byte/half lane.
- Next state: RESP.
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; responses are not back-pressured.
REQ-025 Latency SHALL be counted in cycles from the accepting edge to rsp_valid high:
- error 1;
- load 2;
- word store 2;
- sub-word store 3.
REQ-026 Back-to-back operation: a new request SHALL NOT be accepted before IDLE is re-entered (minimum 1 cycle between rsp_valid and the next accept).
REQ-027 mem_we SHALL be 0 in every state other than STORE; mem_addr SHALL be 0 in IDLE and RESP.
REQ-028 mem_we SHALL be combinationally gated by reset, so that no RAM write occurs on an edge where reset = 0.
REQ-029 Address arithmetic SHALL NOT range-check; addresses beyond the RAM depth pass through unchanged.
REQ-030 req_valid while not in IDLE SHALL be ignored; the requester must hold it until req_ready.

Reset
REQ-031 On reset = 0 at posedge, the block SHALL enter IDLE from any state, aborting any in-flight access.
REQ-032 During and after reset, outputs SHALL be:
- req_ready = 0 while reset = 0, then 1 in IDLE;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
- mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-033 An aborted request SHALL produce no response and no partial write.

Verification
REQ-034 Word load: RAM[5] = 0x8899AABB, load word addr 0x14 -> rsp_valid 2 cycles after accept, rsp_rdata = 0x8899AABB, rsp_err = 0.
REQ-035 Signed byte load: RAM[5] = 0x8899AABB, load byte signed addr 0x17 -> rsp_rdata = 0xFFFFFF88; unsigned -> 0x00000088.
REQ-036 Half store: RAM[2] = 0x11223344, store half 0xBEEF to addr 0x0A -> one mem_we pulse, mem_addr = 2, RAM[2] = 0xBEEF3344, rsp_valid 3 cycles after accept.
REQ-037 Misaligned word load at 0x06 -> rsp_valid next cycle, rsp_err = 1, rsp_rdata = 0, mem_we never high.
REQ-038 Reset mid-RMW: reset = 0 during STORE of a byte store to 0x00 -> RAM[0] unchanged, no rsp_valid, req_ready = 1 the cycle after reset releases.

Source files
------------

// File: rtl/lsu_if.sv
// CPU request/response and word-RAM signals of the load/store unit.
// The slave modport is the LSU side; the master modport is the CPU and RAM side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses to a 32-bit word RAM with sub-word
// read-modify-write, sign/zero extension and misalignment detection.
module lsu (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        access_s;
  logic [31:0] store_word_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane pick followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = 32'd0;
          err_d    = misaligned(bus.req_size, bus.req_addr[1:0]);
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d = S_RESP;
          end else if (!bus.req_we) begin
            state_d = S_LOAD;
          end else if (bus.req_size == 2'b10) begin
            state_d = S_STORE;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rdata_d = load_extract(bus.mem_rdata, size_q, addr_q[1:0], signed_q);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = bus.mem_rdata;
        state_d = S_STORE;
      end
      S_STORE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs are gated by reset so an edge with reset low can never write the RAM.
  always_comb begin
    access_s     = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_STORE);
    store_word_s = (size_q == 2'b10) ? wdata_q : store_merge(merge_q, wdata_q, size_q, addr_q[1:0]);
    bus.req_ready = reset && (state_q == S_IDLE);
    bus.rsp_valid = reset && (state_q == S_RESP);
    bus.rsp_rdata = reset ? rdata_q : 32'd0;
    bus.rsp_err   = reset && err_q;
    bus.mem_we    = reset && (state_q == S_STORE) && we_q;
    bus.mem_addr  = (reset && access_s) ? {2'b00, addr_q[31:2]} : 32'd0;
    bus.mem_wdata = (reset && (state_q == S_STORE)) ? store_word_s : 32'd0;
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed requests push expected responses, a
// negedge monitor pops and compares data, error flag and response cycle.
module tb_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  lsu_if bus ();

  lsu dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ram [0:15];
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] last_we_addr = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign bus.mem_rdata = ram[bus.mem_addr[3:0]];

  // Cycle counter, RAM write port and write-pulse bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
      we_cnt <= we_cnt + 1;
      last_we_addr <= bus.mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int   waited;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_ready", {31'd0, bus.req_ready}, 32'd0);
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  int wc0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 16; i++) ram[i] <= 32'd0;
    ram[0] <= 32'hCAFEF00D;
    ram[2] <= 32'h11223344;
    ram[5] <= 32'h8899AABB;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_mem_addr", bus.mem_addr, 32'd0);

    // Loads from RAM[5] = 8899AABB.
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h8899AABB, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h17, 32'd0, 32'hFFFFFF88, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 32'h00000088, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'hFFFF8899, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'd0, 32'h000000BB, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, 32'h00008899, 1'b0, 2);

    // Half store into upper lane of RAM[2].
    wc0 = we_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000BEEF, 32'd0, 1'b0, 3);
    chk("half_store_pulses", we_cnt - wc0, 32'd1);
    chk("half_store_addr", last_we_addr, 32'd2);
    chk("half_store_ram", ram[2], 32'hBEEF3344);

    // Errors: misaligned word load, illegal size, misaligned half store.
    wc0 = we_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'd0, 1'b1, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 32'd0, 1'b1, 1);
    do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h00001234, 32'd0, 1'b1, 1);
    chk("err_no_write", we_cnt - wc0, 32'd0);

    // Word store then byte store into RAM[8]; upper wdata bits must be ignored.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'd0, 1'b0, 2);
    chk("word_store_ram", ram[8], 32'h12345678);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFA5, 32'd0, 1'b0, 3);
    chk("byte_store_ram", ram[8], 32'h1234A578);
    do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 32'hFFFFFFA5, 1'b0, 2);

    // Reset asserted while a byte store to 0x00 sits in STORE.
    wc0 = we_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h00000055;
    chk("abort_accept_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_store_we", {31'd0, bus.mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we_gated", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    chk("abort_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_ram0", ram[0], 32'hCAFEF00D);
    chk("abort_no_write", we_cnt - wc0, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 32'hCAFEF00D, 1'b0, 2);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
